rf_access_seq: RTL and testbench

RF_ACCESS_SEQ -- requirements
Module: rf_access_seq

---
 rtl/rf_access_seq.sv | 176 +++++++++++++++++
 tb/tb_rf_access_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_seq.sv
`default_nettype none
// ============================================================================
// Module      : rf_access_seq
// Description : Sequences register-file reads and queued writes onto a single
//               registered rf_* port. Read responses use a valid/ready handshake.
//               Optional write-to-read forwarding: define RF_ACCESS_SEQ_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_access_seq #(
  parameter int WQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data1,
  output logic [31:0] resp_data2,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic [4:0]  rf_rd,
  output logic        rf_RW,
  output logic [31:0] rf_dataIn,
  output logic        rf_en,
  input  logic [31:0] rf_readOut1,
  input  logic [31:0] rf_readOut2
);
  localparam int c_PTR_W = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(WQ_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RD_ISSUE = 2'd1,
    S_RD_WAIT  = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t             r_state;
  logic [4:0]         r_wq_addr [WQ_DEPTH];
  logic [31:0]        r_wq_data [WQ_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_pop;

  assign wr_ready = en && (r_count < c_DEPTH);
`ifdef RF_ACCESS_SEQ_FWD_EN
  assign rd_ready = en && (r_state == S_IDLE);
`else
  assign rd_ready = en && (r_state == S_IDLE) && (r_count == '0);
`endif
  assign w_rd_acc = rd_valid && rd_ready;
  assign w_wr_acc = wr_valid && wr_ready;
  // RD_ISSUE is the cycle the file samples the read, so the port is kept free then.
  assign w_pop    = en && (r_state != S_RD_ISSUE) && !w_rd_acc && (r_count != '0);

`ifdef RF_ACCESS_SEQ_FWD_EN
  logic        w_hit1, w_hit2;
  logic [31:0] w_fwd1, w_fwd2;
  logic        r_fwd1_vld, r_fwd2_vld;
  logic [31:0] r_fwd1_data, r_fwd2_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (c_CNT_W'(i) < r_count) begin
        if (r_wq_addr[r_head + c_PTR_W'(i)] == rd_addr1) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_wq_data[r_head + c_PTR_W'(i)];
        end
        if (r_wq_addr[r_head + c_PTR_W'(i)] == rd_addr2) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_wq_data[r_head + c_PTR_W'(i)];
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      resp_valid <= 1'b0;
      resp_data1 <= '0;
      resp_data2 <= '0;
      rf_en      <= 1'b0;
      rf_RW      <= 1'b0;
      rf_rs1     <= '0;
      rf_rs2     <= '0;
      rf_rd      <= '0;
      rf_dataIn  <= '0;
`ifdef RF_ACCESS_SEQ_FWD_EN
      r_fwd1_vld  <= 1'b0;
      r_fwd2_vld  <= 1'b0;
      r_fwd1_data <= '0;
      r_fwd2_data <= '0;
`endif
    end else if (!en) begin
      rf_en <= 1'b0;
    end else begin
      rf_en <= 1'b0;
      if (w_wr_acc) begin
        r_wq_addr[r_tail] <= wr_addr;
        r_wq_data[r_tail] <= wr_data;
        r_tail            <= r_tail + 1'b1;
      end
      if (w_pop) begin
        rf_en     <= 1'b1;
        rf_RW     <= 1'b1;
        rf_rd     <= r_wq_addr[r_head];
        rf_dataIn <= r_wq_data[r_head];
        r_head    <= r_head + 1'b1;
      end
      if (w_wr_acc && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_wr_acc && w_pop)
        r_count <= r_count - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_rd_acc) begin
            r_state <= S_RD_ISSUE;
            rf_en   <= 1'b1;
            rf_RW   <= 1'b0;
            rf_rs1  <= rd_addr1;
            rf_rs2  <= rd_addr2;
`ifdef RF_ACCESS_SEQ_FWD_EN
            r_fwd1_vld  <= w_hit1;
            r_fwd2_vld  <= w_hit2;
            r_fwd1_data <= w_fwd1;
            r_fwd2_data <= w_fwd2;
`endif
          end
        end
        S_RD_ISSUE: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_state    <= S_RESP;
          resp_valid <= 1'b1;
`ifdef RF_ACCESS_SEQ_FWD_EN
          resp_data1 <= r_fwd1_vld ? r_fwd1_data : rf_readOut1;
          resp_data2 <= r_fwd2_vld ? r_fwd2_data : rf_readOut2;
`else
          resp_data1 <= rf_readOut1;
          resp_data2 <= rf_readOut2;
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state    <= S_IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rf_access_seq.sv
`default_nettype none
// Bench for rf_access_seq: directed and random traffic checked against an
// ordered register-file reference (reads see every write accepted before them).
module tb_rf_access_seq;
  localparam int WQ_DEPTH = 4;
`ifdef RF_ACCESS_SEQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data1, resp_data2;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_RW, rf_en;
  logic [31:0] rf_dataIn;
  logic [31:0] rf_readOut1, rf_readOut2;

  always #5 clk = ~clk;

  rf_access_seq #(.WQ_DEPTH(WQ_DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data1(resp_data1), .resp_data2(resp_data2),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_RW(rf_RW),
    .rf_dataIn(rf_dataIn), .rf_en(rf_en),
    .rf_readOut1(rf_readOut1), .rf_readOut2(rf_readOut2)
  );

  // Register file attached to the rf_* port: read data appears the cycle after sampling.
  logic [31:0] mem [32];
  logic [31:0] init_mem [32];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else if (rf_en) begin
      if (rf_RW) mem[rf_rd] <= rf_dataIn;
      else begin
        rf_readOut1 <= mem[rf_rs1];
        rf_readOut2 <= mem[rf_rs2];
      end
    end
  end

  typedef struct packed { logic [31:0] d1; logic [31:0] d2; } rd_exp_t;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wr_exp_t;

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  logic [31:0] ref_mem [32];
  logic [31:0] committed [32];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_wr_commit = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        issue_pend = 1'b0;
  logic        resp_seen = 1'b0;
  logic [4:0]  pend_a1, pend_a2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: samples 1 ns before each rising edge.
  initial begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    logic    exp_rd;
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
    init_mem[3] = 32'h11;
    init_mem[4] = 32'h22;
    ref_mem   = init_mem;
    committed = init_mem;
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (rf_en && rf_RW) begin
        if (wr_q.size() == 0) fail_now("unexpected_rf_write");
        else begin
          we = wr_q.pop_front();
          chk("rf_write_addr", 64'(rf_rd), 64'(we.a));
          chk("rf_write_data", 64'(rf_dataIn), 64'(we.d));
          committed[we.a] = we.d;
          n_wr_commit++;
        end
      end
      if (issue_pend) begin
        chk("rd_issue_en", 64'(rf_en), 64'd1);
        chk("rd_issue_rw", 64'(rf_RW), 64'd0);
        chk("rd_issue_rs1", 64'(rf_rs1), 64'(pend_a1));
        chk("rd_issue_rs2", 64'(rf_rs2), 64'(pend_a2));
        issue_pend = 1'b0;
      end else if (rf_en && !rf_RW) fail_now("unexpected_rf_read");

      if (reset) begin
        rd_q.delete();
        wr_q.delete();
        resp_seen = 1'b0;
        ref_mem = committed;
      end else begin
        exp_rd = en && (rd_q.size() == 0) && (FWD || wr_q.size() == 0);
        chk("wr_ready", 64'(wr_ready), 64'(en && (wr_q.size() < WQ_DEPTH)));
        chk("rd_ready", 64'(rd_ready), 64'(exp_rd));
        if (resp_valid) begin
          if (rd_q.size() == 0) fail_now("spurious_resp_valid");
          else begin
            re = rd_q[0];
            if (!resp_seen) begin
              chk("resp_latency", 64'(cyc - acc_cyc), 64'd3);
              resp_seen = 1'b1;
            end
            chk("resp_data1", 64'(resp_data1), 64'(re.d1));
            chk("resp_data2", 64'(resp_data2), 64'(re.d2));
            if (resp_ready && en) begin
              void'(rd_q.pop_front());
              resp_seen = 1'b0;
            end
          end
        end
        // A read accepted on the same edge as a write is ordered before it.
        if (en && rd_valid && rd_ready) begin
          re.d1 = ref_mem[rd_addr1];
          re.d2 = ref_mem[rd_addr2];
          rd_q.push_back(re);
          issue_pend = 1'b1;
          pend_a1 = rd_addr1;
          pend_a2 = rd_addr2;
          acc_cyc = cyc;
        end
        if (en && wr_valid && wr_ready) begin
          ref_mem[wr_addr] = wr_data;
          we.a = wr_addr;
          we.d = wr_data;
          wr_q.push_back(we);
        end
      end
    end
  end

  task automatic push_write(input logic [4:0] a, input logic [31:0] d);
    int budget = 50;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #4;
    while (!wr_ready && budget > 0) begin
      @(negedge clk); #4;
      budget--;
    end
    if (budget == 0) fail_now("push_write_timeout");
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic push_read(input logic [4:0] a1, input logic [4:0] a2);
    int budget = 50;
    rd_valid = 1'b1; rd_addr1 = a1; rd_addr2 = a2;
    #4;
    while (!rd_ready && budget > 0) begin
      @(negedge clk); #4;
      budget--;
    end
    if (budget == 0) fail_now("push_read_timeout");
    @(negedge clk);
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((rd_q.size() != 0 || wr_q.size() != 0) && b < 300) begin
      @(negedge clk);
      b++;
    end
    if (b >= 300) fail_now("wait_idle_timeout");
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int hold;
    int commits0;
    reset = 1'b1; en = 1'b1; preload = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr1 = '0; rd_addr2 = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; preload = 1'b0;
    #4;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data1", 64'(resp_data1), 64'd0);
    chk("rst_resp_data2", 64'(resp_data2), 64'd0);
    chk("rst_rf_en", 64'(rf_en), 64'd0);
    chk("rst_rf_RW", 64'(rf_RW), 64'd0);
    chk("rst_rf_addrs", 64'({rf_rs1, rf_rs2, rf_rd}), 64'd0);
    chk("rst_rf_dataIn", 64'(rf_dataIn), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk);

    // Basic read of preloaded registers 3 and 4
    rd_valid = 1'b1; rd_addr1 = 5'd3; rd_addr2 = 5'd4;
    #4 chk("basic_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk); rd_valid = 1'b0;
    #4 chk("basic_rf_en", 64'({rf_en, rf_RW, resp_valid}), 64'b100);
    @(negedge clk);
    #4 chk("basic_cycle2_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    #4 chk("basic_cycle3_valid", 64'(resp_valid), 64'd1);
    chk("basic_data", 64'({resp_data1, resp_data2}), {32'h11, 32'h22});
    @(negedge clk);
    wait_idle();

    // Five back-to-back writes, committed in order
    for (int i = 0; i < 5; i++) push_write(5'(20 + i), 32'h100 + 32'(i));
    wait_idle();

    // Read after a queued write to the same register
    push_write(5'd7, 32'hAB);
    push_read(5'd7, 5'd7);
    wait_idle();

    // Youngest queued write to a register wins
    push_write(5'd9, 32'h1);
    push_write(5'd9, 32'h2);
    push_read(5'd9, 5'd0);
    wait_idle();

    // Reset while a read is waiting with writes queued
    rd_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD0001;
    #4 chk("rst_mid_rd_ready", 64'(rd_ready), 64'd1);
    @(negedge clk);
    rd_valid = 1'b0; wr_addr = 5'd6; wr_data = 32'hDEAD0002;
    @(negedge clk);
    wr_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #4;
    chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_mid_rf_en", 64'(rf_en), 64'd0);
    chk("rst_mid_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_mid_rd_ready", 64'(rd_ready), 64'd1);
    repeat (6) @(negedge clk);

    // Response back-pressure while writes keep draining
    resp_ready = 1'b0;
    push_read(5'd12, 5'd0);
    commits0 = n_wr_commit;
    hold = 0;
    rd_valid = 1'b1; rd_addr1 = 5'd1; rd_addr2 = 5'd2;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_addr = 5'(16 + i); wr_data = $urandom;
      #4 if (resp_valid) hold++;
      @(negedge clk);
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    chk("resp_hold_cycles", 64'(hold >= 5), 64'd1);
    chk("drain_during_hold", 64'((n_wr_commit - commits0) >= 4), 64'd1);
    resp_ready = 1'b1;
    wait_idle();

    // Enable low: readies drop and no register-file operation is issued
    en = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1;
    @(negedge clk);
    #4 chk("en_low_rf_en", 64'(rf_en), 64'd0);
    repeat (2) @(negedge clk);
    wr_valid = 1'b0; rd_valid = 1'b0; en = 1'b1;
    @(negedge clk);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      wr_valid   = ($urandom_range(0, 99) < 50);
      wr_addr    = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wr_data    = $urandom;
      rd_valid   = ($urandom_range(0, 99) < 35);
      rd_addr1   = 5'($urandom_range(0, 7));
      rd_addr2   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      resp_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_valid = 1'b0; resp_ready = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
